counter_share_arbiter: RTL and testbench
========================================

Name: counter_share_arbiter

Overview:
- Shares one 8-bit up-counting interval timer between NREQ requesters using round-robin arbitration.
- Each requester asks for an interval of len cycles. The winner is granted, the counter runs from 0 to len, and the winner then gets a one-cycle done pulse.
- Sits between client blocks and the shared counter datapath. It sequences load, count and release so that only one client owns the counter at any time.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, counter and interval width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; forces all state and outputs to reset values immediately while low
req  input  NREQ  per-requester request level; must be held until done or the requester aborts
len  input  NREQ*WIDTH  packed interval lengths; requester i uses bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant; all zero when no owner
done  output  NREQ  one-cycle completion pulse to the owner
busy  output  1  high whenever state is not IDLE
count  output  WIDTH  current counter value

Behaviour:
- Reset values: state=IDLE, gnt=0, done=0, busy=0, count=0, round-robin pointer ptr=0, owner=0, target=0.
- States: IDLE, COUNT, DONE.
- IDLE, no req bit set: remain in IDLE; count=0.
- IDLE, any req bit set: winner = first set req bit scanning ptr, ptr+1, ..., wrapping modulo NREQ. On that edge:
  - owner<=winner, target<=len slice of winner (the only sampling point for len), count<=0.
  - gnt<=onehot(winner), state<=COUNT.
- COUNT, req[owner]=1:
  - count==target: state<=DONE, gnt<=0, done[owner]<=1, count holds.
  - otherwise: count<=count+1.
- COUNT, req[owner]=0 (abort): state<=IDLE, gnt<=0, count<=0, no done pulse, ptr<=(owner+1) mod NREQ.
- DONE: done<=0, count<=0, ptr<=(owner+1) mod NREQ, state<=IDLE. The req level is ignored in DONE.
- Timing for an uncontended request:
  - gnt is high for exactly len+1 cycles, with count taking values 0..len.
  - done is high for exactly 1 cycle, starting the cycle after the last gnt cycle.
  - Earliest next grant is on the edge after the DONE cycle's successor edge, i.e. back-to-back grants are len+3 cycles apart.
- len=0: gnt high 1 cycle with count=0, then done.
- len=2^WIDTH-1: count reaches 255 without overflow; count never wraps.
- Changes to len or to other req bits during COUNT have no effect.
- A new request that appears in the DONE cycle waits for IDLE.
- Simultaneous requests: the pointer guarantees fairness; no requester waits more than NREQ-1 grants.
- Reset asserted mid-operation: immediate return to reset values. No done pulse is issued for the interrupted owner.
- Invariants (for assertions): gnt is zero or one-hot; done is zero or one-hot; gnt and done are never simultaneously nonzero; busy == (state != IDLE).

Test Plan:
- Single request: req=0001, len0=3 held → gnt=0001 for 4 cycles with count 0,1,2,3; done=0001 for 1 cycle; then busy=0 and count=0.
- Contention: req=1011 all held, all len=1, ptr=0 → grant order 0,1,3,0, each spaced 4 cycles (len+3); gnt never overlaps done.
- Zero length: req=0100, len2=0 → gnt=0100 for 1 cycle with count=0, then done=0100 for 1 cycle.
- Abort: req=0010, len1=10; drop req1 when count=4 → next cycle gnt=0, count=0, no done pulse; next grant starts the scan from requester 2.
- Reset mid-count: len=200, assert reset when count=50 → outputs go to 0 asynchronously without waiting for clk; after release with req still high, a new grant starts from requester 0 with count=0.
- Max length: len3=255, req=1000 → gnt high for 256 cycles, count ends at 255 with no wrap, then done=1000.

Source files
------------

// File: rtl/counter_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_share_arbiter
// Description : Round-robin arbiter that shares one up-counting interval
//               timer between NREQ requesters. The winner is granted, the
//               counter runs 0..len, then the winner receives a one-cycle
//               done pulse and the pointer advances past it.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous, active-low reset
//               req    - per-requester request level
//               len    - packed interval lengths, requester i at [i*WIDTH +: WIDTH]
//               gnt    - one-hot grant to the current owner (zero when none)
//               done   - one-cycle completion pulse to the owner
//               busy   - high whenever the arbiter is not idle
//               count  - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module counter_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state,  w_state_nxt;
  logic [PW-1:0]     r_ptr,    w_ptr_nxt;
  logic [PW-1:0]     r_owner,  w_owner_nxt;
  logic [WIDTH-1:0]  r_target, w_target_nxt;
  logic [WIDTH-1:0]  r_count,  w_count_nxt;
  logic [NREQ-1:0]   r_gnt,    w_gnt_nxt;
  logic [NREQ-1:0]   r_done,   w_done_nxt;

  logic [PW-1:0]     w_winner;
  logic              w_any_req;
  logic [PW-1:0]     w_owner_inc;

  // Round-robin scan starting at r_ptr. Iterating from the farthest offset
  // down to offset 0 lets the closest requester overwrite earlier hits.
  always_comb begin
    int idx;
    w_winner  = '0;
    w_any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (req[idx]) begin
        w_winner  = PW'(idx);
        w_any_req = 1'b1;
      end
    end
  end

  // Pointer value that places the current owner last in the next scan.
  assign w_owner_inc = (int'(r_owner) == NREQ - 1) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_owner_nxt  = r_owner;
    w_target_nxt = r_target;
    w_count_nxt  = r_count;
    w_gnt_nxt    = r_gnt;
    w_done_nxt   = '0;

    case (r_state)
      IDLE: begin
        w_count_nxt = '0;
        if (w_any_req) begin
          w_owner_nxt           = w_winner;
          // len is sampled only here; later changes do not affect the interval.
          w_target_nxt          = len[int'(w_winner)*WIDTH +: WIDTH];
          w_gnt_nxt             = '0;
          w_gnt_nxt[w_winner]   = 1'b1;
          w_state_nxt           = COUNT;
        end
      end

      COUNT: begin
        if (req[r_owner]) begin
          if (r_count == r_target) begin
            // Count holds at target so it never wraps, even at all-ones.
            w_state_nxt         = DONE;
            w_gnt_nxt           = '0;
            w_done_nxt[r_owner] = 1'b1;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end else begin
          // Owner withdrew: release without a done pulse.
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_count_nxt = '0;
          w_ptr_nxt   = w_owner_inc;
        end
      end

      DONE: begin
        w_count_nxt = '0;
        w_ptr_nxt   = w_owner_inc;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_target <= '0;
      r_count  <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_target <= w_target_nxt;
      r_count  <= w_count_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign busy  = (r_state != IDLE);
  assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_share_arbiter
// Description : Self-checking bench for counter_share_arbiter. A behavioural
//               model tracks owner / interval / pointer as plain integers and
//               predicts every output each cycle; directed scenarios are
//               followed by a randomized phase with aborts and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;

  counter_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: m_owner = -1 means no interval running,
  // m_done_who >= 0 means this cycle is the completion cycle.
  int m_owner, m_cnt, m_tgt, m_ptr, m_done_who;

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_tgt = 0; m_ptr = 0; m_done_who = -1;
  endtask

  task automatic model_edge();
    int w;
    if (m_done_who >= 0) begin
      m_ptr      = (m_done_who + 1) % NREQ;
      m_done_who = -1;
      m_cnt      = 0;
    end else if (m_owner < 0) begin
      m_cnt = 0;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      if (w >= 0) begin
        m_owner = w;
        m_tgt   = int'(len[w*WIDTH +: WIDTH]);
        m_cnt   = 0;
      end
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = -1;
      m_cnt   = 0;
    end else if (m_cnt == m_tgt) begin
      m_done_who = m_owner;
      m_owner    = -1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic compare_outputs(input string where);
    logic [NREQ-1:0] eg, ed;
    eg = '0; ed = '0;
    if (m_owner >= 0)    eg[m_owner]    = 1'b1;
    if (m_done_who >= 0) ed[m_done_who] = 1'b1;
    check_value({where, ".gnt"},   32'(gnt),   32'(eg));
    check_value({where, ".done"},  32'(done),  32'(ed));
    check_value({where, ".busy"},  32'(busy),  32'(m_owner >= 0 || m_done_who >= 0));
    check_value({where, ".count"}, 32'(count), 32'(m_cnt));
    check_value({where, ".gnt_onehot0"},  32'($onehot0(gnt)),  32'd1);
    check_value({where, ".done_onehot0"}, 32'($onehot0(done)), 32'd1);
    check_value({where, ".gnt_done_excl"}, 32'((|gnt) && (|done)), 32'd0);
  endtask

  int              cyc;
  int              gnt_cycles, done_cycles;
  int              grant_who[$];
  int              grant_cyc[$];
  logic [NREQ-1:0] prev_gnt;

  task automatic clear_stats();
    gnt_cycles = 0; done_cycles = 0;
    grant_who.delete(); grant_cyc.delete();
  endtask

  task automatic step(input string where);
    @(posedge clk);
    if (reset) model_edge();
    else       model_reset();
    cyc++;
    #1;
    compare_outputs(where);
    if (gnt != 0)  gnt_cycles++;
    if (done != 0) done_cycles++;
    if (prev_gnt == 0 && gnt != 0) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) grant_who.push_back(i);
      grant_cyc.push_back(cyc);
    end
    prev_gnt = gnt;
  endtask

  // Assert reset between clock edges and confirm outputs clear immediately.
  task automatic async_reset(input string where);
    reset = 1'b0;
    model_reset();
    #1;
    compare_outputs(where);
    prev_gnt = gnt;
  endtask

  task automatic run_until_done(input string where, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      step(where);
      if (done != 0) break;
    end
    check_value({where, ".done_seen"}, 32'(done_cycles), 32'd1);
  endtask

  initial begin
    cyc = 0; prev_gnt = '0;
    clear_stats();
    req = '0; len = '0; reset = 1'b0;
    model_reset();
    #1;
    compare_outputs("reset_state");
    step("reset_hold");
    step("reset_hold");
    reset = 1'b1;
    step("idle");

    // Single request, len0 = 3.
    clear_stats();
    req = 4'b0001; len[0*WIDTH +: WIDTH] = 8'd3;
    run_until_done("single", 20);
    check_value("single.gnt_cycles", 32'(gnt_cycles), 32'd4);
    req = '0;
    step("single_tail");
    step("single_idle");
    check_value("single.idle_busy",  32'(busy),  32'd0);
    check_value("single.idle_count", 32'(count), 32'd0);

    // Zero length on requester 2.
    clear_stats();
    req = 4'b0100; len[2*WIDTH +: WIDTH] = 8'd0;
    run_until_done("zero", 10);
    check_value("zero.gnt_cycles", 32'(gnt_cycles), 32'd1);
    req = '0;
    repeat (2) step("zero_tail");

    // Maximum length on requester 3.
    clear_stats();
    req = 4'b1000; len[3*WIDTH +: WIDTH] = 8'd255;
    run_until_done("max", 300);
    check_value("max.gnt_cycles", 32'(gnt_cycles), 32'd256);
    check_value("max.count_at_done", 32'(count), 32'd255);
    req = '0;
    repeat (2) step("max_tail");

    // Contention from a fresh pointer.
    @(posedge clk); #1;
    async_reset("cont_rst");
    step("cont_rst_hold");
    reset = 1'b1;
    clear_stats();
    len = {NREQ{8'd1}};
    req = 4'b1011;
    repeat (18) step("cont");
    req = '0;
    repeat (3) step("cont_tail");
    check_value("cont.n_grants_ge4", 32'(grant_who.size() >= 4), 32'd1);
    if (grant_who.size() >= 4) begin
      check_value("cont.order0", 32'(grant_who[0]), 32'd0);
      check_value("cont.order1", 32'(grant_who[1]), 32'd1);
      check_value("cont.order2", 32'(grant_who[2]), 32'd3);
      check_value("cont.order3", 32'(grant_who[3]), 32'd0);
      for (int i = 1; i < 4; i++)
        check_value("cont.spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd4);
    end

    // Abort: requester 1 drops its request at count 4.
    clear_stats();
    req = 4'b0010; len[1*WIDTH +: WIDTH] = 8'd10;
    for (int i = 0; i < 30; i++) begin
      step("abort_run");
      if (count == 8'd4) break;
    end
    check_value("abort.reach4", 32'(count), 32'd4);
    req = '0;
    step("abort_edge");
    check_value("abort.gnt",   32'(gnt),   32'd0);
    check_value("abort.count", 32'(count), 32'd0);
    len = {NREQ{8'd1}};
    req = 4'b1111;
    step("abort_regrant");
    check_value("abort.next_from2", 32'(gnt), 32'b0100);
    check_value("abort.no_done", 32'(done_cycles), 32'd0);
    req = '0;
    repeat (5) step("abort_tail");

    // Reset in the middle of a long interval.
    req = 4'b0001; len[0*WIDTH +: WIDTH] = 8'd200;
    for (int i = 0; i < 80; i++) begin
      step("rstmid_run");
      if (count == 8'd50) break;
    end
    check_value("rstmid.reach50", 32'(count), 32'd50);
    async_reset("rstmid_async");
    check_value("rstmid.gnt0",   32'(gnt),   32'd0);
    check_value("rstmid.count0", 32'(count), 32'd0);
    step("rstmid_hold");
    reset = 1'b1;
    step("rstmid_regrant");
    check_value("rstmid.regrant", 32'(gnt), 32'b0001);
    check_value("rstmid.count",   32'(count), 32'd0);
    req = '0;
    repeat (4) step("rstmid_tail");

    // Randomized phase: requests come and go (aborts), lengths vary,
    // occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 7) == 0) req[r] = ~req[r];
        if ($urandom_range(0, 3) == 0)
          len[r*WIDTH +: WIDTH] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40))
                                                              : 8'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rand_rst");
        step("rand_rst_hold");
        reset = 1'b1;
      end
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
